// File: rtl/tf_fifo_ctrl.sv
// Twiddle-factor FIFO sequencer: prefills a small FIFO from a fixed-latency ROM,
// then grants butterfly requests while keeping the FIFO topped up without over/underflow.
module tf_fifo_ctrl #(
    parameter int unsigned FLOAT_LEN   = 32,
    parameter int unsigned TF_NUM      = 4,
    parameter int unsigned TF_TOTAL    = 8,
    parameter int unsigned TF_ADDR_LEN = 3,
    parameter int unsigned ROM_LAT     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rom_en,
    output logic [TF_ADDR_LEN-1:0]   rom_addr,
    input  logic [2*FLOAT_LEN-1:0]   rom_data,
    output logic                     fifo_wr_en,
    output logic [2*FLOAT_LEN-1:0]   fifo_din,
    output logic                     fifo_rd_en,
    input  logic [2*FLOAT_LEN-1:0]   fifo_dout,
    input  logic                     fifo_full,
    input  logic                     fifo_empty,
    input  logic                     bf_req,
    output logic                     bf_gnt,
    output logic [2*FLOAT_LEN-1:0]   tf_out,
    output logic                     tf_valid,
    output logic                     err
);

    localparam int unsigned CW = $clog2(TF_TOTAL + 1);
    localparam logic [CW-1:0] TOTAL_W = CW'(TF_TOTAL);
    localparam logic [CW-1:0] NUM_W   = CW'(TF_NUM);
    localparam logic [CW:0]   NUM_P   = (CW + 1)'(TF_NUM);

    typedef enum logic [1:0] {StIdle, StPrefill, StRun} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic [CW-1:0]      infl_q, infl_d;
    logic [CW-1:0]      iss_q, iss_d;
    logic [CW-1:0]      cons_q, cons_d;
    logic [ROM_LAT-1:0] vld_q, vld_d;
    logic               tf_valid_q;
    logic               err_q;
    logic               active;
    logic [CW:0]        pending;

    assign active  = (state_q == StPrefill) || (state_q == StRun);
    // Committed entries plus reads in flight: the space the FIFO is already promised.
    assign pending = {1'b0, occ_q} + {1'b0, infl_q};

    assign rom_en     = active && (iss_q < TOTAL_W) && (pending < NUM_P);
    assign rom_addr   = iss_q[TF_ADDR_LEN-1:0];
    assign fifo_wr_en = vld_q[ROM_LAT-1];
    assign fifo_din   = rom_data;

    // occ counts committed writes only, so a write landing this cycle never enables a read.
    assign bf_gnt     = bf_req && (state_q == StRun) && (occ_q != '0) && (cons_q < TOTAL_W);
    assign fifo_rd_en = bf_gnt;
    assign tf_out     = fifo_dout;
    assign tf_valid   = tf_valid_q;
    assign done       = (state_q == StRun) && tf_valid_q && (cons_q == TOTAL_W);
    assign busy       = (state_q != StIdle);
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q + CW'(fifo_wr_en) - CW'(fifo_rd_en);
        infl_d  = infl_q + CW'(rom_en) - CW'(fifo_wr_en);
        iss_d   = iss_q + CW'(rom_en);
        cons_d  = cons_q + CW'(bf_gnt);
        vld_d   = ROM_LAT'({vld_q, rom_en});
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPrefill;
                    occ_d   = '0;
                    infl_d  = '0;
                    iss_d   = '0;
                    cons_d  = '0;
                end
            end
            StPrefill: begin
                if ((occ_q == NUM_W) || ((iss_q == TOTAL_W) && (infl_q == '0))) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            occ_q      <= '0;
            infl_q     <= '0;
            iss_q      <= '0;
            cons_q     <= '0;
            vld_q      <= '0;
            tf_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            infl_q     <= infl_d;
            iss_q      <= iss_d;
            cons_q     <= cons_d;
            vld_q      <= vld_d;
            tf_valid_q <= bf_gnt;
            if ((fifo_wr_en && fifo_full) || (fifo_rd_en && fifo_empty)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tf_fifo_ctrl.sv
// Directed bench for tf_fifo_ctrl with a 2-cycle ROM model, a 4-entry FIFO model
// and a per-cycle monitor for ordering, latency and occupancy.
module tb_tf_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, rom_en;
    logic [2:0]  rom_addr;
    logic [63:0] rom_data;
    logic        fifo_wr_en, fifo_rd_en;
    logic [63:0] fifo_din, fifo_dout;
    logic        fifo_full, fifo_empty;
    logic        bf_req = 1'b0;
    logic        bf_gnt;
    logic [63:0] tf_out;
    logic        tf_valid, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tf_fifo_ctrl #(
        .FLOAT_LEN  (32),
        .TF_NUM     (4),
        .TF_TOTAL   (8),
        .TF_ADDR_LEN(3),
        .ROM_LAT    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .bf_req    (bf_req),
        .bf_gnt    (bf_gnt),
        .tf_out    (tf_out),
        .tf_valid  (tf_valid),
        .err       (err)
    );

    function automatic logic [63:0] word(input logic [31:0] a);
        return {a, ~a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ROM: two-stage pipe, not reset, so stale returns can arrive after a DUT reset
    logic       rp_v0 = 1'b0, rp_v1 = 1'b0;
    logic [2:0] rp_a0 = '0, rp_a1 = '0;
    always @(posedge clk) begin
        rp_v0 <= rom_en;
        rp_a0 <= rom_addr;
        rp_v1 <= rp_v0;
        rp_a1 <= rp_a0;
    end
    assign rom_data = word(32'(rp_a1));

    // FIFO model with registered read data
    logic [63:0] fmem [4];
    logic [1:0]  fwp, frp;
    logic [2:0]  fcnt;
    logic [63:0] fdout;
    logic        force_full = 1'b0;
    logic        f_wr, f_rd;
    assign f_wr       = fifo_wr_en && (fcnt != 3'd4);
    assign f_rd       = fifo_rd_en && (fcnt != 3'd0);
    assign fifo_full  = (fcnt == 3'd4) || force_full;
    assign fifo_empty = (fcnt == 3'd0);
    assign fifo_dout  = fdout;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fwp <= '0; frp <= '0; fcnt <= '0; fdout <= '0;
        end else begin
            if (f_wr) begin
                fmem[fwp] <= fifo_din;
                fwp <= fwp + 2'd1;
            end
            if (f_rd) begin
                fdout <= fmem[frp];
                frp <= frp + 2'd1;
            end
            fcnt <= fcnt + 3'(f_wr) - 3'(f_rd);
        end
    end

    // Monitor: in-order data, grant-to-valid latency, occupancy bound, single done
    logic mon_en = 1'b0;
    logic gnt_prev = 1'b0;
    int   exp_idx, n_valid, n_done, pend;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid_lat", 64'(tf_valid), 64'(gnt_prev));
            if (tf_valid) begin
                chk("tf_out", tf_out, word(32'(exp_idx)));
                exp_idx++;
                n_valid++;
            end
            if (done) begin
                n_done++;
                chk("done_with_last", 64'(exp_idx), 64'd8);
            end
            pend = int'(fcnt) + int'(rp_v0) + int'(rp_v1);
            chk("occ_bound", 64'(pend <= 4), 64'd1);
            if (bf_gnt) chk("gnt_nonempty", 64'(fcnt != 3'd0), 64'd1);
            chk("err_clear", 64'(err), 64'd0);
            gnt_prev = bf_gnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_begin();
        exp_idx  = 0;
        n_valid  = 0;
        n_done   = 0;
        gnt_prev = 1'b0;
        mon_en   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat [4] = '{1, 0, 0, 1};
        // Reset state
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rom_en", 64'(rom_en), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_wr", 64'(fifo_wr_en), 64'd0);
        chk("rst_rd", 64'(fifo_rd_en), 64'd0);
        chk("rst_valid", 64'(tf_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        tick();

        // Reset mid-PREFILL with reads in flight
        start = 1'b1; tick(); start = 1'b0;
        chk("mr_rom_en", 64'(rom_en), 64'd1);
        tick();
        rst = 1'b1; #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_rom_en0", 64'(rom_en), 64'd0);
        chk("mr_addr", 64'(rom_addr), 64'd0);
        chk("mr_wr", 64'(fifo_wr_en), 64'd0);
        chk("mr_gnt", 64'(bf_gnt), 64'd0);
        chk("mr_valid", 64'(tf_valid), 64'd0);
        chk("mr_err", 64'(err), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mr_no_wr", 64'(fifo_wr_en), 64'd0);
        end
        chk("mr_err_after", 64'(err), 64'd0);

        // Prefill then streaming
        frame_begin();
        start = 1'b1; tick(); start = 1'b0;
        chk("pf_c1_en", 64'(rom_en), 64'd1);
        chk("pf_c1_addr", 64'(rom_addr), 64'd0);
        chk("pf_c1_busy", 64'(busy), 64'd1);
        tick();
        chk("pf_c2_en", 64'(rom_en), 64'd1);
        chk("pf_c2_addr", 64'(rom_addr), 64'd1);
        chk("pf_c2_wr", 64'(fifo_wr_en), 64'd0);
        tick();
        chk("pf_c3_addr", 64'(rom_addr), 64'd2);
        chk("pf_c3_wr", 64'(fifo_wr_en), 64'd1);
        chk("pf_c3_din", fifo_din, word(32'd0));
        tick();
        chk("pf_c4_en", 64'(rom_en), 64'd1);
        chk("pf_c4_addr", 64'(rom_addr), 64'd3);
        chk("pf_c4_din", fifo_din, word(32'd1));
        tick();
        chk("pf_c5_en", 64'(rom_en), 64'd0);
        chk("pf_c5_wr", 64'(fifo_wr_en), 64'd1);
        tick();
        chk("pf_c6_wr", 64'(fifo_wr_en), 64'd1);
        chk("pf_c6_din", fifo_din, word(32'd3));
        tick();
        bf_req = 1'b1; #1;
        chk("pf_c7_no_gnt", 64'(bf_gnt), 64'd0);
        chk("pf_c7_en", 64'(rom_en), 64'd0);
        tick();
        chk("st_c8_gnt", 64'(bf_gnt), 64'd1);
        chk("st_c8_no5th", 64'(rom_en), 64'd0);
        tick();
        chk("st_c9_en", 64'(rom_en), 64'd1);
        chk("st_c9_addr", 64'(rom_addr), 64'd4);
        chk("st_c9_out", tf_out, word(32'd0));
        repeat (6) tick();
        chk("st_c15_gnt", 64'(bf_gnt), 64'd1);
        tick();
        chk("st_c16_done", 64'(done), 64'd1);
        chk("st_c16_gnt", 64'(bf_gnt), 64'd0);
        chk("st_c16_out", tf_out, word(32'd7));
        tick();
        chk("st_c17_busy", 64'(busy), 64'd0);
        chk("st_c17_done", 64'(done), 64'd0);
        bf_req = 1'b0;
        chk("st_ndone", 64'(n_done), 64'd1);
        chk("st_nvalid", 64'(n_valid), 64'd8);

        // Start during RUN and start coinciding with done are both ignored
        frame_begin();
        bf_req = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("pr_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 60 && done !== 1'b1; i++) tick();
        chk("pr_done_seen", 64'(done), 64'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("pr_idle", 64'(busy), 64'd0);
        tick();
        chk("pr_still_idle", 64'(busy), 64'd0);
        chk("pr_no_issue", 64'(rom_en), 64'd0);
        bf_req = 1'b0;
        chk("pr_ndone", 64'(n_done), 64'd1);
        chk("pr_nvalid", 64'(n_valid), 64'd8);

        // Back-pressure: 1-0-0-1 request pattern with random gaps
        frame_begin();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 400 && busy; k++) begin
            bf_req = pat[k % 4][0];
            tick();
            bf_req = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        chk("bp_finished", 64'(busy), 64'd0);
        chk("bp_ndone", 64'(n_done), 64'd1);
        chk("bp_nvalid", 64'(n_valid), 64'd8);

        // Write while flagged full sets a sticky error
        mon_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10 && !fifo_wr_en; i++) tick();
        chk("ef_wr_seen", 64'(fifo_wr_en), 64'd1);
        chk("ef_err_pre", 64'(err), 64'd0);
        force_full = 1'b1;
        tick();
        force_full = 1'b0;
        chk("ef_err_set", 64'(err), 64'd1);
        repeat (3) tick();
        chk("ef_err_sticky", 64'(err), 64'd1);
        rst = 1'b1; #1;
        chk("ef_err_rst", 64'(err), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("ef_err_after", 64'(err), 64'd0);
        chk("ef_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tf_fifo_ctrl.md
Name: tf_fifo_ctrl

Overview:
- Sequencer for the 4-entry twiddle-factor FIFO in a radix stage.
- On start, fetches TF_TOTAL complex twiddle factors in address order from the twiddle ROM (fixed read latency) and prefills the FIFO.
- Grants butterfly requests, keeps the FIFO topped up, and guarantees the FIFO never sees a write when full or a read when empty, including its unsafe simultaneous read/write at zero occupancy.

Parameters:
- FLOAT_LEN, 32, bits per real/imag float; data word is 2*FLOAT_LEN.
- TF_NUM, 4, FIFO depth.
- TF_TOTAL, 8, twiddles per frame (power of 2, >= TF_NUM).
- TF_ADDR_LEN, 3, log2(TF_TOTAL); ROM address width.
- ROM_LAT, 2, ROM cycles from rom_en to rom_data valid (>= 1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  frame start pulse; accepted only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse with the last tf_valid of a frame.
- rom_en  out  1  ROM read strobe.
- rom_addr  out  TF_ADDR_LEN  ROM address.
- rom_data  in  2*FLOAT_LEN  ROM data, valid ROM_LAT cycles after rom_en.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  2*FLOAT_LEN  FIFO write data; equals rom_data.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_dout  in  2*FLOAT_LEN  FIFO read data, registered in the FIFO.
- fifo_full  in  1  FIFO full flag; used only for the error check.
- fifo_empty  in  1  FIFO empty flag; used only for the error check.
- bf_req  in  1  butterfly requests one twiddle, level-sensitive.
- bf_gnt  out  1  request granted this cycle (combinational).
- tf_out  out  2*FLOAT_LEN  twiddle to butterfly; equals fifo_dout.
- tf_valid  out  1  tf_out valid, one cycle after bf_gnt.
- err  out  1  sticky protocol error.

Behaviour:
Reset:
- State IDLE. All counters cleared, ROM valid pipe cleared.
- Outputs: busy 0, done 0, rom_en 0, rom_addr 0, fifo_wr_en 0, fifo_rd_en 0, bf_gnt 0, tf_valid 0, err 0.
- Reset mid-frame abandons the frame; in-flight ROM returns are discarded and no FIFO write is issued after reset.
- The FIFO has its own reset; both blocks share rst.

Internal state:
- occ (0..TF_NUM): entries committed in the FIFO.
- infl (0..ROM_LAT): ROM reads in flight.
- iss (0..TF_TOTAL): reads issued.
- cons (0..TF_TOTAL): twiddles granted.

Issue rule:
- rom_en = 1 when state is PREFILL or RUN, iss < TF_TOTAL, and occ + infl < TF_NUM.
- rom_addr = iss (registered counter). iss increments on issue.

Return:
- A valid bit enters a ROM_LAT-deep shift pipe on each issue.
- fifo_wr_en = pipe tap; fifo_din = rom_data in the same cycle.

Grant rule:
- bf_gnt = bf_req and state RUN and occ > 0 and cons < TF_TOTAL.
- fifo_rd_en = bf_gnt.
- A read with occ == 0 is never issued, even when a write lands the same cycle; the request is granted on a later cycle.
- tf_valid is registered and high the cycle after bf_gnt. tf_out = fifo_dout.

Counter updates:
- occ += fifo_wr_en - fifo_rd_en.
- infl += rom_en - fifo_wr_en.
- cons increments on bf_gnt.

FSM:
- IDLE -> PREFILL on start. Counters are zeroed on entry.
- PREFILL -> RUN when occ == TF_NUM, or when iss == TF_TOTAL and infl == 0. No grants occur in PREFILL.
- RUN -> IDLE on the cycle after the final grant, i.e. the tf_valid cycle with cons == TF_TOTAL. done = 1 in that cycle.
- start is ignored outside IDLE.
- A start coinciding with done is ignored; the next start must arrive in IDLE.

Error check:
- err sets if fifo_wr_en while fifo_full, or fifo_rd_en while fifo_empty.
- err clears only on rst.

Latency and width:
- start to first rom_en: 1 cycle.
- rom_en to fifo_wr_en: ROM_LAT cycles.
- bf_gnt to tf_valid: 1 cycle.
- No arithmetic on data; data passes through unmodified.
- Counter width is sized to hold TF_TOTAL inclusive.

Test Plan:
(Parameters: TF_NUM=4, TF_TOTAL=8, ROM_LAT=2. ROM model returns data = {addr, ~addr} per 32-bit half.)
- Reset mid-PREFILL, 1 cycle after start, with reads in flight -> all outputs 0; no fifo_wr_en in the following 5 cycles; err 0.
- Prefill: start with bf_req=0 -> rom_en on 4 consecutive cycles, addr 0,1,2,3; fifo_wr_en 2 cycles later on each; RUN entered with occ=4; no 5th read issued.
- Streaming: bf_req held high after RUN -> 8 grants, tf_out sequence addr 0..7 in order; refill reads overlap grants; err stays 0; done pulses exactly once, with the 8th tf_valid.
- Starvation: from occ=0 with a write landing, bf_req=1 -> no bf_gnt that cycle; grant the next cycle; tf_out = next in-order word; no lost data.
- Back-pressure: bf_req toggled 1-0-0-1 with random gaps -> rom_en never raises occ+infl above 4; every tf_valid is exactly 1 cycle after bf_gnt.
- Protocol: start pulsed during RUN -> ignored, frame completes normally. Bench forces fifo_full=1 during a write -> err=1, sticky until rst.
